// File: rtl/stage_if_if.sv
// IFID / I-cache / redirect bundle shared by the fetch stage and its neighbours.
// The master modport is the fetch stage; the slave side is decode, the cache and EX.
interface stage_if_if #(
   parameter int N_THREADS = 4,
   parameter int TID_W     = $clog2(N_THREADS)
);
   logic             id_stall;
   logic             id_itlb_miss;
   logic             id_icache_miss;
   logic [31:0]      id_pc;
   logic [31:0]      id_instruction;
   logic [TID_W-1:0] id_thread;

   logic             ic_req;
   logic [31:0]      ic_addr;
   logic [TID_W-1:0] ic_thread;
   logic             ic_hit;
   logic [31:0]      ic_rdata;
   logic             itlb_miss;
   logic             ic_fill_done;
   logic [TID_W-1:0] ic_fill_thread;

   logic             ex_redirect;
   logic [TID_W-1:0] ex_redirect_thread;
   logic [31:0]      ex_redirect_pc;

   modport master (
      input  id_stall, ic_hit, ic_rdata, itlb_miss, ic_fill_done, ic_fill_thread,
             ex_redirect, ex_redirect_thread, ex_redirect_pc,
      output id_itlb_miss, id_icache_miss, id_pc, id_instruction, id_thread,
             ic_req, ic_addr, ic_thread
   );

   modport slave (
      output id_stall, ic_hit, ic_rdata, itlb_miss, ic_fill_done, ic_fill_thread,
             ex_redirect, ex_redirect_thread, ex_redirect_pc,
      input  id_itlb_miss, id_icache_miss, id_pc, id_instruction, id_thread,
             ic_req, ic_addr, ic_thread
   );
endinterface

// File: rtl/stage_if.sv
// Multithreaded instruction-fetch stage: round-robin thread pick, I-cache/I-TLB
// lookup and IFID register, with per-thread miss/redirect tracking.
module stage_if #(
   parameter int          N_THREADS = 4,
   parameter logic [31:0] BOOT_PC   = 32'h0000_1000,
   parameter int          TID_W     = $clog2(N_THREADS)
) (
   input logic         clk,
   input logic         rst,
   stage_if_if.master  bus
);

   typedef enum logic [1:0] {
      READY         = 2'd0,
      WAIT_FILL     = 2'd1,
      WAIT_REDIRECT = 2'd2
   } thrState_e;

   thrState_e        state_q [N_THREADS];
   thrState_e        state_d [N_THREADS];
   logic [31:0]      pc_q    [N_THREADS];
   logic [31:0]      pc_d    [N_THREADS];
   logic [TID_W-1:0] last_q, last_d;

   logic             idItlbMiss_q, idItlbMiss_d;
   logic             idIcacheMiss_q, idIcacheMiss_d;
   logic [31:0]      idPc_q, idPc_d;
   logic [31:0]      idInstr_q, idInstr_d;
   logic [TID_W-1:0] idThread_q, idThread_d;

   logic             selFound;
   logic             selValid;
   logic [TID_W-1:0] selThread;
   logic [TID_W-1:0] cand;

   // Round-robin search starting after the last issuer; k == N_THREADS wraps
   // back onto last itself, and a thread being redirected this cycle is skipped.
   always_comb begin
      selFound  = 1'b0;
      selThread = '0;
      cand      = '0;
      for (int k = 1; k <= N_THREADS; k++) begin
         cand = last_q + TID_W'(k);
         if (!selFound && state_q[cand] == READY &&
             !(bus.ex_redirect && bus.ex_redirect_thread == cand)) begin
            selFound  = 1'b1;
            selThread = cand;
         end
      end
   end

   assign selValid      = selFound && !bus.id_stall;
   assign bus.ic_req    = selValid;
   assign bus.ic_addr   = pc_q[selThread];
   assign bus.ic_thread = selThread;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      last_d         = last_q;
      idItlbMiss_d   = idItlbMiss_q;
      idIcacheMiss_d = idIcacheMiss_q;
      idPc_d         = idPc_q;
      idInstr_d      = idInstr_q;
      idThread_d     = idThread_q;

      for (int t = 0; t < N_THREADS; t++) begin
         if (bus.ic_fill_done && bus.ic_fill_thread == TID_W'(t) && state_q[t] == WAIT_FILL)
            state_d[t] = READY;
      end

      if (selValid) begin
         last_d     = selThread;
         idThread_d = selThread;
         idPc_d     = pc_q[selThread];
         if (bus.itlb_miss) begin
            idItlbMiss_d       = 1'b1;
            idIcacheMiss_d     = 1'b0;
            idInstr_d          = '0;
            state_d[selThread] = WAIT_REDIRECT;
         end else if (!bus.ic_hit) begin
            idItlbMiss_d       = 1'b0;
            idIcacheMiss_d     = 1'b1;
            idInstr_d          = '0;
            state_d[selThread] = WAIT_FILL;
         end else begin
            idItlbMiss_d    = 1'b0;
            idIcacheMiss_d  = 1'b0;
            idInstr_d       = bus.ic_rdata;
            pc_d[selThread] = pc_q[selThread] + 32'd4;
         end
      end else if (!bus.id_stall) begin
         idItlbMiss_d   = 1'b0;
         idIcacheMiss_d = 1'b1;
         idInstr_d      = '0;
      end

      // Redirect is applied last so it overrides a same-cycle fill.
      for (int t = 0; t < N_THREADS; t++) begin
         if (bus.ex_redirect && bus.ex_redirect_thread == TID_W'(t)) begin
            pc_d[t]    = bus.ex_redirect_pc;
            state_d[t] = READY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < N_THREADS; t++) begin
            state_q[t] <= READY;
            pc_q[t]    <= BOOT_PC;
         end
         last_q         <= TID_W'(N_THREADS - 1);
         idItlbMiss_q   <= 1'b0;
         idIcacheMiss_q <= 1'b1;
         idPc_q         <= '0;
         idInstr_q      <= '0;
         idThread_q     <= '0;
      end else begin
         for (int t = 0; t < N_THREADS; t++) begin
            state_q[t] <= state_d[t];
            pc_q[t]    <= pc_d[t];
         end
         last_q         <= last_d;
         idItlbMiss_q   <= idItlbMiss_d;
         idIcacheMiss_q <= idIcacheMiss_d;
         idPc_q         <= idPc_d;
         idInstr_q      <= idInstr_d;
         idThread_q     <= idThread_d;
      end
   end

   assign bus.id_itlb_miss   = idItlbMiss_q;
   assign bus.id_icache_miss = idIcacheMiss_q;
   assign bus.id_pc          = idPc_q;
   assign bus.id_instruction = idInstr_q;
   assign bus.id_thread      = idThread_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: the cache model returns the address as the
// instruction word, with per-thread masks forcing I-cache and I-TLB misses.
module tb_stage_if;

   localparam int N_THREADS = 4;
   localparam int TID_W     = 2;

   logic clk;
   logic rst;
   logic [N_THREADS-1:0] missMask;
   logic [N_THREADS-1:0] itlbMask;
   int checkCount;
   int passCount;

   stage_if_if #(.N_THREADS(N_THREADS), .TID_W(TID_W)) bus ();

   stage_if #(.N_THREADS(N_THREADS), .BOOT_PC(32'h0000_1000), .TID_W(TID_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Combinational cache/TLB model answering the current lookup.
   assign bus.ic_hit    = ~missMask[bus.ic_thread];
   assign bus.ic_rdata  = bus.ic_addr;
   assign bus.itlb_miss = itlbMask[bus.ic_thread];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic checkIfid(input string tag, input int thr, input logic [31:0] pc,
                            input logic [31:0] instr, input logic icMiss, input logic tlbMiss);
      checkOutput({tag, ".thread"}, 32'(bus.id_thread), 32'(thr));
      checkOutput({tag, ".pc"}, bus.id_pc, pc);
      checkOutput({tag, ".instr"}, bus.id_instruction, instr);
      checkOutput({tag, ".icmiss"}, 32'(bus.id_icache_miss), 32'(icMiss));
      checkOutput({tag, ".itlb"}, 32'(bus.id_itlb_miss), 32'(tlbMiss));
   endtask

   task automatic checkReset(input string tag);
      checkIfid(tag, 0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic applyStimulus(input logic redir, input int rThr, input logic [31:0] rPc,
                                input logic fill, input int fThr);
      bus.ex_redirect        = redir;
      bus.ex_redirect_thread = TID_W'(rThr);
      bus.ex_redirect_pc     = rPc;
      bus.ic_fill_done       = fill;
      bus.ic_fill_thread     = TID_W'(fThr);
   endtask

   // One clock: outputs settle 1 time unit after the edge, then pulses drop.
   task automatic tick();
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 0, 32'h0, 1'b0, 0);
   endtask

   task automatic issue(input string tag, input int thr, input logic [31:0] pc);
      tick();
      checkIfid(tag, thr, pc, pc, 1'b0, 1'b0);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      missMask   = '0;
      itlbMask   = '0;
      rst        = 1'b0;
      bus.id_stall = 1'b0;
      applyStimulus(1'b0, 0, 32'h0, 1'b0, 0);

      #12;
      checkReset("rst0");
      checkOutput("boot.ic_req", 32'(bus.ic_req), 32'd1);
      checkOutput("boot.ic_thread", 32'(bus.ic_thread), 32'd0);
      checkOutput("boot.ic_addr", bus.ic_addr, 32'h1000);
      rst = 1'b1;

      issue("rr0", 0, 32'h1000);
      issue("rr1", 1, 32'h1000);
      issue("rr2", 2, 32'h1000);
      issue("rr3", 3, 32'h1000);
      issue("rr4", 0, 32'h1004);

      // Reset mid-run restarts everything at the boot PC.
      rst = 1'b0;
      #2;
      checkReset("rst1");
      rst = 1'b1;
      missMask = 4'b0010;

      issue("mA", 0, 32'h1000);
      tick();
      checkIfid("mB", 1, 32'h1000, 32'h0, 1'b1, 1'b0);
      issue("mC", 2, 32'h1000);
      issue("mD", 3, 32'h1000);
      issue("mE", 0, 32'h1004);
      issue("mF", 2, 32'h1004);
      missMask[1] = 1'b0;
      applyStimulus(1'b0, 0, 32'h0, 1'b1, 1);
      issue("mG", 3, 32'h1004);
      issue("mH", 0, 32'h1008);
      issue("mI", 1, 32'h1000);

      // Drive every thread into WAIT_FILL.
      missMask = 4'b1111;
      tick(); checkIfid("wJ", 2, 32'h1008, 32'h0, 1'b1, 1'b0);
      tick(); checkIfid("wK", 3, 32'h1008, 32'h0, 1'b1, 1'b0);
      tick(); checkIfid("wL", 0, 32'h100C, 32'h0, 1'b1, 1'b0);
      tick(); checkIfid("wM", 1, 32'h1004, 32'h0, 1'b1, 1'b0);
      checkOutput("allwait.ic_req0", 32'(bus.ic_req), 32'd0);
      tick(); checkIfid("bubN", 1, 32'h1004, 32'h0, 1'b1, 1'b0);
      checkOutput("allwait.ic_req1", 32'(bus.ic_req), 32'd0);
      missMask[2] = 1'b0;
      applyStimulus(1'b0, 0, 32'h0, 1'b1, 2);
      tick(); checkIfid("bubO", 1, 32'h1004, 32'h0, 1'b1, 1'b0);
      checkOutput("fill2.ic_req", 32'(bus.ic_req), 32'd1);
      checkOutput("fill2.ic_thread", 32'(bus.ic_thread), 32'd2);
      checkOutput("fill2.ic_addr", bus.ic_addr, 32'h1008);
      issue("fP", 2, 32'h1008);

      // I-TLB miss parks thread 3 until a redirect.
      missMask[3] = 1'b0;
      itlbMask[3] = 1'b1;
      applyStimulus(1'b0, 0, 32'h0, 1'b1, 3);
      issue("tQ", 2, 32'h100C);
      tick(); checkIfid("tR", 3, 32'h1008, 32'h0, 1'b0, 1'b1);
      issue("tS", 2, 32'h1010);
      issue("tT", 2, 32'h1014);
      itlbMask[3] = 1'b0;
      applyStimulus(1'b1, 3, 32'h2000, 1'b0, 0);
      issue("tU", 2, 32'h1018);
      issue("tV", 3, 32'h2000);
      issue("tW", 2, 32'h101C);
      issue("tX", 3, 32'h2004);

      // Stall window with a redirect of thread 0 inside it.
      missMask[0] = 1'b0;
      bus.id_stall = 1'b1;
      #1;
      checkOutput("stall.ic_req", 32'(bus.ic_req), 32'd0);
      issue("s1", 3, 32'h2004);
      applyStimulus(1'b1, 0, 32'h3000, 1'b0, 0);
      issue("s2", 3, 32'h2004);
      issue("s3", 3, 32'h2004);
      bus.id_stall = 1'b0;
      #1;
      checkOutput("unstall.ic_req", 32'(bus.ic_req), 32'd1);
      checkOutput("unstall.ic_thread", 32'(bus.ic_thread), 32'd0);
      checkOutput("unstall.ic_addr", bus.ic_addr, 32'h3000);
      issue("u0", 0, 32'h3000);
      issue("u1", 2, 32'h1020);
      issue("u2", 3, 32'h2008);

      // Redirect and fill for the same waiting thread in one cycle.
      missMask[1] = 1'b0;
      applyStimulus(1'b1, 1, 32'h4000, 1'b1, 1);
      issue("rf0", 0, 32'h3004);
      issue("rf1", 1, 32'h4000);

      // Redirecting the thread that would be picked hands the slot onward.
      applyStimulus(1'b1, 2, 32'h5000, 1'b0, 0);
      #1;
      checkOutput("excl.ic_thread", 32'(bus.ic_thread), 32'd3);
      checkOutput("excl.ic_addr", bus.ic_addr, 32'h200C);
      issue("ex0", 3, 32'h200C);
      issue("ex1", 0, 32'h3008);
      issue("ex2", 1, 32'h4004);
      applyStimulus(1'b1, 3, 32'hFFFF_FFFC, 1'b0, 0);
      issue("ex3", 2, 32'h5000);

      // PC increment wraps from the top of the address space to zero.
      issue("wr0", 3, 32'hFFFF_FFFC);
      issue("wr1", 0, 32'h300C);
      issue("wr2", 1, 32'h4008);
      issue("wr3", 2, 32'h5004);
      issue("wr4", 3, 32'h0000_0000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
